motor_pwm_ctrl: RTL

//  Downstream consumer of the TFF divided-clock stage in the Mini Motor design.

---
 rtl/motor_pwm_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/motor_pwm_ctrl.sv
// rtl/motor_pwm_ctrl.sv - H-bridge PWM leg driver clocked by synchronised T_IN ticks,
// with a fixed dead time inserted on every direction change.
module motor_pwm_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEAD_TICKS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             T_IN,
  input  logic [WIDTH-1:0] DUTY,
  input  logic             DIR_REQ,
  output logic             PWM_A,
  output logic             PWM_B,
  output logic             DIR,
  output logic             BUSY,
  output logic             PERIOD_END
);

  localparam int            DW        = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);

  typedef enum logic {RUN, DEAD} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;
  logic [WIDTH-1:0]       cnt, cnt_n, cnt_inc;
  logic [WIDTH-1:0]       duty_q, duty_n, duty_eff;
  logic [DW-1:0]          dead_cnt, dead_n;
  logic                   dir_q, dir_n;
  logic                   pwm_a_n, pwm_b_n, pend_n;
  logic                   wrap, on;

  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign BUSY = (state == DEAD);
  assign DIR  = dir_q;

  // T_IN is asynchronous; only its synchronised rising edge is used.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], T_IN};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= RUN;
    else        state <= state_n;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt        <= '0;
      duty_q     <= '0;
      dead_cnt   <= '0;
      dir_q      <= 1'b0;
      PWM_A      <= 1'b0;
      PWM_B      <= 1'b0;
      PERIOD_END <= 1'b0;
    end else begin
      cnt        <= cnt_n;
      duty_q     <= duty_n;
      dead_cnt   <= dead_n;
      dir_q      <= dir_n;
      PWM_A      <= pwm_a_n;
      PWM_B      <= pwm_b_n;
      PERIOD_END <= pend_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    duty_n   = duty_q;
    dead_n   = dead_cnt;
    dir_n    = dir_q;
    pwm_a_n  = PWM_A;
    pwm_b_n  = PWM_B;
    pend_n   = 1'b0;
    wrap     = (cnt == {WIDTH{1'b1}});
    cnt_inc  = cnt + WIDTH'(1);
    duty_eff = wrap ? DUTY : duty_q;
    on       = (cnt_inc < duty_eff);
    case (state)
      RUN: begin
        // A direction mismatch wins over a coincident tick: legs drop immediately.
        if (DIR_REQ != dir_q) begin
          state_n = DEAD;
          dead_n  = '0;
          pwm_a_n = 1'b0;
          pwm_b_n = 1'b0;
        end else if (tick) begin
          cnt_n   = cnt_inc;
          pwm_a_n = on & ~dir_q;
          pwm_b_n = on & dir_q;
          if (wrap) begin
            duty_n = DUTY;
            pend_n = 1'b1;
          end
        end
      end
      DEAD: begin
        pwm_a_n = 1'b0;
        pwm_b_n = 1'b0;
        if (tick) begin
          if (dead_cnt == DEAD_LAST) begin
            state_n = RUN;
            dir_n   = DIR_REQ;
            cnt_n   = '0;
            duty_n  = DUTY;
          end else begin
            dead_n = dead_cnt + DW'(1);
          end
        end
      end
      default: state_n = RUN;
    endcase
  end

endmodule
